// File: rtl/lvt_memory.sv
// lvt_memory: multi-ported RAM built from per-port write banks plus a
// Live Value Table (LVT) that records, per address, which port wrote last.
// Every port may write and read in the same cycle; reads are registered
// (one-cycle latency) and select the live bank through the LVT.
//
// Optional build macro: LVT_BYPASS_EN
//   defined   -> write-first forwarding: a read of an address being written
//                at the same edge returns the new data (highest writer wins).
//   undefined -> read-before-write: the reader sees the pre-edge value.
module lvt_memory #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PORTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] addr [PORTS],
  input  logic                     en   [PORTS],
  input  logic [WIDTH-1:0]         d    [PORTS],
  output logic [WIDTH-1:0]         q    [PORTS]
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  // Storage: one bank per writing port, plus the live-value table.
  logic [WIDTH-1:0] bank_q [PORTS][DEPTH];
  logic [WIDTH-1:0] bank_d [PORTS][DEPTH];
  logic [LW-1:0]    lvt_q  [DEPTH];
  logic [LW-1:0]    lvt_d  [DEPTH];
  logic [WIDTH-1:0] q_q    [PORTS];
  logic [WIDTH-1:0] q_d    [PORTS];
  logic             we_s   [PORTS];
  logic             inr_s  [PORTS];

  // Addresses at or beyond DEPTH (non-power-of-2 depths) are not backed by storage.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Qualify each port's address and write enable.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      inr_s[p] = in_range(addr[p]);
      we_s[p]  = en[p] & inr_s[p];
    end
  end

  // Next bank/LVT contents: each writer updates its own bank; ascending port
  // order makes the highest writing index own the LVT entry on a collision.
  always_comb begin
    bank_d = bank_q;
    lvt_d  = lvt_q;
    for (int p = 0; p < PORTS; p++) begin
      if (we_s[p]) begin
        bank_d[p][addr[p]] = d[p];
        lvt_d[addr[p]]     = LW'(p);
      end else begin
        // read-only this cycle: bank and LVT hold
        lvt_d[0] = lvt_d[0];
      end
    end
  end

  // Next read data: live bank selected by the pre-edge LVT, optionally
  // overridden by a same-edge write when forwarding is built in.
  always_comb begin
    for (int r = 0; r < PORTS; r++) begin
      if (inr_s[r]) begin
        q_d[r] = bank_q[lvt_q[addr[r]]][addr[r]];
      end else begin
        q_d[r] = '0;
      end
`ifdef LVT_BYPASS_EN
      for (int p = 0; p < PORTS; p++) begin
        if (we_s[p] && inr_s[r] && (addr[p] == addr[r])) begin
          q_d[r] = d[p];
        end else begin
          q_d[r] = q_d[r];
        end
      end
`endif
    end
  end

  // State registers: banks, LVT and read-data outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) begin
        q_q[p] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          bank_q[p][i] <= '0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        lvt_q[i] <= '0;
      end
    end else begin
      bank_q <= bank_d;
      lvt_q  <= lvt_d;
      q_q    <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_lvt_memory.sv
// Directed self-checking bench for lvt_memory (default parameters).
// Expected values are hand-computed constants; build with LVT_BYPASS_EN
// defined to check the forwarding variant.
module tb_lvt_memory;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PORTS = 4;
  localparam int AW    = 3;

  logic             clk;
  logic             rst_n;
  logic [AW-1:0]    addr [PORTS];
  logic             en   [PORTS];
  logic [WIDTH-1:0] d    [PORTS];
  logic [WIDTH-1:0] q    [PORTS];

  int n_cmp;
  int n_err;

  lvt_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .en   (en),
    .d    (d),
    .q    (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_read(input logic [AW-1:0] a);
    for (int p = 0; p < PORTS; p++) begin
      en[p]   = 1'b0;
      addr[p] = a;
      d[p]    = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] rdw_exp;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    all_read(3'd0);

    // Reset state
    #12;
    for (int p = 0; p < PORTS; p++) check_val($sformatf("reset_q%0d", p), 32'(q[p]), 32'h0);
    rst_n = 1'b1;

    // Basic cross-port read: port0 writes 42 to address 5
    en[0] = 1'b1; addr[0] = 3'd5; d[0] = 8'd42;
    tick();
    all_read(3'd0);
    addr[1] = 3'd5;
    tick();
    check_val("xport_q1", 32'(q[1]), 32'd42);
    check_val("xport_q0_addr0", 32'(q[0]), 32'd0);

    // Concurrent distinct writes: port p writes 0x10+0x11*p to address p
    for (int p = 0; p < PORTS; p++) begin
      en[p] = 1'b1; addr[p] = AW'(p); d[p] = 8'(8'h10 + 8'h11 * p);
    end
    tick();
    for (int k = 0; k < PORTS; k++) begin
      for (int r = 0; r < PORTS; r++) begin
        en[r] = 1'b0; addr[r] = AW'((r + k) % PORTS);
      end
      tick();
      for (int r = 0; r < PORTS; r++) begin
        check_val($sformatf("distinct_p%0d_a%0d", r, (r + k) % PORTS), 32'(q[r]),
                  32'(8'h10 + 8'h11 * ((r + k) % PORTS)));
      end
    end

    // Same-address collision: port1 0xAA and port3 0xBB to address 2
    all_read(3'd6);
    en[1] = 1'b1; addr[1] = 3'd2; d[1] = 8'hAA;
    en[3] = 1'b1; addr[3] = 3'd2; d[3] = 8'hBB;
    tick();
    all_read(3'd2);
    tick();
    for (int p = 0; p < PORTS; p++) check_val($sformatf("collide_q%0d", p), 32'(q[p]), 32'hBB);
    en[0] = 1'b1; d[0] = 8'hCC;
    tick();
    all_read(3'd2);
    tick();
    for (int p = 0; p < PORTS; p++) check_val($sformatf("rewrite_q%0d", p), 32'(q[p]), 32'hCC);

    // Read-during-write at address 4
    all_read(3'd4);
    en[0] = 1'b1; d[0] = 8'h11;
    tick();
    all_read(3'd4);
    en[2] = 1'b1; d[2] = 8'h22;
`ifdef LVT_BYPASS_EN
    rdw_exp = 8'h22;
`else
    rdw_exp = 8'h11;
`endif
    tick();
    check_val("rdw_q0_same_edge", 32'(q[0]), 32'(rdw_exp));
    check_val("rdw_q2_self", 32'(q[2]), 32'(rdw_exp));
    all_read(3'd4);
    tick();
    check_val("rdw_q0_after", 32'(q[0]), 32'h22);

    // Overwrite by same port on consecutive cycles at address 7
    all_read(3'd7);
    en[0] = 1'b1; d[0] = 8'd1;
    tick();
    d[0] = 8'd2;
    tick();
    all_read(3'd7);
    tick();
    check_val("overwrite_q3", 32'(q[3]), 32'd2);

    // Mid-run reset: q must clear without a clock edge, then memory reads zero
    all_read(3'd5);
    tick();
    check_val("pre_reset_q1", 32'(q[1]), 32'd42);
    #1;
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < PORTS; p++) check_val($sformatf("async_rst_q%0d", p), 32'(q[p]), 32'h0);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      all_read(AW'(a));
      tick();
      for (int p = 0; p < PORTS; p++) begin
        check_val($sformatf("post_rst_p%0d_a%0d", p, a), 32'(q[p]), 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
